// File: rtl/mem_access_seq_pkg.sv
// Shared constants for the load/store sequencer: opcodes, datapath select
// codes, size encodings and the FSM state type.
package mem_access_seq_pkg;

  localparam logic [5:0] OP_LB = 6'b100000;
  localparam logic [5:0] OP_LH = 6'b100001;
  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SB = 6'b101000;
  localparam logic [5:0] OP_SH = 6'b101001;
  localparam logic [5:0] OP_SW = 6'b101011;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  localparam logic [1:0] IOD_PC     = 2'b00;
  localparam logic [1:0] IOD_ALUOUT = 2'b01;

  localparam logic [2:0] MTR_MEM = 3'b001;
  localparam logic [1:0] RDC_RT  = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_RD_WAIT, S_RD_LATCH, S_WB, S_WR, S_DONE
  } state_e;

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  // Access width is carried in the two low opcode bits of every load/store.
  function automatic logic [1:0] op_size(input logic [1:0] op_lo);
    case (op_lo)
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] lsb);
    case (sz)
      SZ_WORD: return lsb != 2'b00;
      SZ_HALF: return lsb[0];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_seq.sv
// Load/store sequencer: walks memory read latency, MDR capture, write-back or
// read-modify-write, and reports completion or alignment/opcode exceptions.
module mem_access_seq
  import mem_access_seq_pkg::*;
#(
  parameter int MEM_LAT = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] op_code,
  input  logic [1:0] addr_lsb,
  output logic       busy,
  output logic       done,
  output logic       exc_align,
  output logic       exc_opcode,
  output logic [1:0] i_or_d,
  output logic       memory_write,
  output logic       mdr_write,
  output logic [1:0] load_size,
  output logic [1:0] store_size,
  output logic       reg_write,
  output logic [2:0] mem_to_reg,
  output logic [1:0] reg_dist_ctrl
);

  state_e     state_q, state_d;
  logic [5:0] op_q, op_d;
  logic [1:0] lsb_q, lsb_d;
  logic [2:0] cnt_q, cnt_d;

  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       exc_align_q, exc_align_d;
  logic       exc_opcode_q, exc_opcode_d;
  logic [1:0] i_or_d_q, i_or_d_d;
  logic       memory_write_q, memory_write_d;
  logic       mdr_write_q, mdr_write_d;
  logic [1:0] load_size_q, load_size_d;
  logic [1:0] store_size_q, store_size_d;
  logic       reg_write_q, reg_write_d;
  logic [2:0] mem_to_reg_q, mem_to_reg_d;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    lsb_d        = lsb_q;
    cnt_d        = cnt_q;
    exc_align_d  = 1'b0;
    exc_opcode_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op_code;
          lsb_d   = addr_lsb;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!(is_load(op_q) || is_store(op_q))) begin
          exc_opcode_d = 1'b1;
          state_d      = S_IDLE;
        end else if (misaligned(op_size(op_q[1:0]), lsb_q)) begin
          exc_align_d = 1'b1;
          state_d     = S_IDLE;
        end else if (op_q == OP_SW) begin
          state_d = S_WR;
        end else begin
          // Sub-word stores also read first so the merger can preserve other bytes.
          cnt_d   = 3'(MEM_LAT - 1);
          state_d = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (cnt_q == 3'd0) state_d = S_RD_LATCH;
        else               cnt_d   = cnt_q - 3'd1;
      end
      S_RD_LATCH: state_d = is_load(op_q) ? S_WB : S_WR;
      S_WB:       state_d = S_DONE;
      S_WR:       state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so the registered copies
  // line up with the state they belong to.
  always_comb begin
    busy_d         = (state_d != S_IDLE);
    done_d         = (state_d == S_DONE);
    i_or_d_d       = IOD_PC;
    memory_write_d = (state_d == S_WR);
    mdr_write_d    = (state_d == S_RD_LATCH);
    reg_write_d    = (state_d == S_WB);
    mem_to_reg_d   = (state_d == S_WB) ? MTR_MEM : 3'b000;
    load_size_d    = SZ_WORD;
    store_size_d   = SZ_WORD;
    if (state_d == S_RD_WAIT || state_d == S_RD_LATCH || state_d == S_WR)
      i_or_d_d = IOD_ALUOUT;
    if (state_d != S_IDLE && is_load(op_d))
      load_size_d = op_size(op_d[1:0]);
    if (state_d != S_IDLE && is_store(op_d))
      store_size_d = op_size(op_d[1:0]);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= S_IDLE;
      op_q           <= 6'd0;
      lsb_q          <= 2'd0;
      cnt_q          <= 3'd0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      exc_align_q    <= 1'b0;
      exc_opcode_q   <= 1'b0;
      i_or_d_q       <= IOD_PC;
      memory_write_q <= 1'b0;
      mdr_write_q    <= 1'b0;
      load_size_q    <= SZ_WORD;
      store_size_q   <= SZ_WORD;
      reg_write_q    <= 1'b0;
      mem_to_reg_q   <= 3'b000;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      lsb_q          <= lsb_d;
      cnt_q          <= cnt_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      exc_align_q    <= exc_align_d;
      exc_opcode_q   <= exc_opcode_d;
      i_or_d_q       <= i_or_d_d;
      memory_write_q <= memory_write_d;
      mdr_write_q    <= mdr_write_d;
      load_size_q    <= load_size_d;
      store_size_q   <= store_size_d;
      reg_write_q    <= reg_write_d;
      mem_to_reg_q   <= mem_to_reg_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign exc_align     = exc_align_q;
  assign exc_opcode    = exc_opcode_q;
  assign i_or_d        = i_or_d_q;
  assign memory_write  = memory_write_q;
  assign mdr_write     = mdr_write_q;
  assign load_size     = load_size_q;
  assign store_size    = store_size_q;
  assign reg_write     = reg_write_q;
  assign mem_to_reg    = mem_to_reg_q;
  assign reg_dist_ctrl = RDC_RT;

endmodule

// File: tb/tb_mem_access_seq.sv
// Scoreboard bench for mem_access_seq: two instances (MEM_LAT 2 and 5) share
// stimulus; a timeline model predicts every output cycle by cycle.
`timescale 1ns/1ps
module tb_mem_access_seq;

  localparam int NI  = 2;
  localparam int INF = 32'h7fff_ffff;

  typedef struct {
    int          cyc;
    logic [17:0] vec;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [5:0] op_code = 6'd0;
  logic [1:0] addr_lsb = 2'd0;
  logic [17:0] obs [NI];

  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  bit   mon_en = 1'b0;
  int   free_at [NI];
  exp_t exp_q [NI][$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    logic       busy, done, exc_align, exc_opcode, memory_write, mdr_write, reg_write;
    logic [1:0] i_or_d, load_size, store_size, reg_dist_ctrl;
    logic [2:0] mem_to_reg;
    mem_access_seq #(.MEM_LAT(gi == 0 ? 2 : 5)) u_dut (
      .clock(clock), .reset(reset), .start(start), .op_code(op_code),
      .addr_lsb(addr_lsb), .busy(busy), .done(done), .exc_align(exc_align),
      .exc_opcode(exc_opcode), .i_or_d(i_or_d), .memory_write(memory_write),
      .mdr_write(mdr_write), .load_size(load_size), .store_size(store_size),
      .reg_write(reg_write), .mem_to_reg(mem_to_reg), .reg_dist_ctrl(reg_dist_ctrl)
    );
    assign obs[gi] = {busy, done, exc_align, exc_opcode, i_or_d, memory_write,
                      mdr_write, load_size, store_size, reg_write, mem_to_reg,
                      reg_dist_ctrl};
  end

  function automatic logic [17:0] pk(bit bz, bit dn, bit ea, bit eo, bit alu,
                                     bit mw, bit mdw, logic [1:0] ls,
                                     logic [1:0] ss, bit rw);
    return {bz, dn, ea, eo, (alu ? 2'b01 : 2'b00), mw, mdw, ls, ss, rw,
            (rw ? 3'b001 : 3'b000), 2'b00};
  endfunction

  function automatic logic [5:0] pick_op(int n);
    case (n)
      0: return 6'b100000;  1: return 6'b100001;  2: return 6'b100011;
      3: return 6'b101000;  4: return 6'b101001;  5: return 6'b101011;
      6: return 6'b001000;  7: return 6'b100010;  8: return 6'b000000;
      default: return 6'b101010;
    endcase
  endfunction

  // Reference timeline: one CHECK cycle, MEM_LAT wait cycles and a latch
  // cycle when memory must be read, one action cycle, one done cycle.
  task automatic model_accept(int i, int t, logic [5:0] op, logic [1:0] lsb);
    int lat   = (i == 0) ? 2 : 5;
    bit ld    = (op == 6'b100000) || (op == 6'b100001) || (op == 6'b100011);
    bit st    = (op == 6'b101000) || (op == 6'b101001) || (op == 6'b101011);
    int bytes = (op[1:0] == 2'b11) ? 4 : (op[1:0] == 2'b01) ? 2 : 1;
    logic [1:0] sz  = (bytes == 4) ? 2'b00 : (bytes == 2) ? 2'b01 : 2'b10;
    logic [1:0] lsz = ld ? sz : 2'b00;
    logic [1:0] ssz = st ? sz : 2'b00;
    int k = t + 2;
    exp_q[i].push_back('{t + 1, pk(1, 0, 0, 0, 0, 0, 0, lsz, ssz, 0)});
    if (!ld && !st) begin
      exp_q[i].push_back('{t + 2, pk(0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 0)});
      free_at[i] = t + 2;
      return;
    end
    if ((int'(lsb) % bytes) != 0) begin
      exp_q[i].push_back('{t + 2, pk(0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0)});
      free_at[i] = t + 2;
      return;
    end
    if (op != 6'b101011) begin
      for (int j = 0; j < lat; j++) begin
        exp_q[i].push_back('{k, pk(1, 0, 0, 0, 1, 0, 0, lsz, ssz, 0)});
        k++;
      end
      exp_q[i].push_back('{k, pk(1, 0, 0, 0, 1, 0, 1, lsz, ssz, 0)});
      k++;
    end
    if (ld) exp_q[i].push_back('{k, pk(1, 0, 0, 0, 0, 0, 0, lsz, ssz, 1)});
    else    exp_q[i].push_back('{k, pk(1, 0, 0, 0, 1, 1, 0, lsz, ssz, 0)});
    k++;
    exp_q[i].push_back('{k, pk(1, 1, 0, 0, 0, 0, 0, lsz, ssz, 0)});
    free_at[i] = k + 1;
  endtask

  // Present one cycle of inputs and update the model, then advance a cycle.
  task automatic drive(bit s, logic [5:0] op, logic [1:0] lsb, bit r);
    start = s; op_code = op; addr_lsb = lsb; reset = r;
    for (int i = 0; i < NI; i++) begin
      if (r) begin
        while (exp_q[i].size() > 0 && exp_q[i][exp_q[i].size()-1].cyc > cyc)
          void'(exp_q[i].pop_back());
        free_at[i] = INF;
      end else begin
        if (free_at[i] == INF) free_at[i] = cyc;
        if (s && cyc >= free_at[i]) model_accept(i, cyc, op, lsb);
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic issue(logic [5:0] op, logic [1:0] lsb);
    int guard = 0;
    while (!(cyc >= free_at[0] && cyc >= free_at[1]) && guard < 100) begin
      drive(0, 6'd0, 2'd0, 0);
      guard++;
    end
    if (guard >= 100) begin
      fails++;
      $display("FAIL idle_wait: model still busy after %0d cycles, required idle", guard);
    end
    drive(1, op, lsb, 0);
  endtask

  // Monitor: each cycle, compare every instance against the scheduled vector
  // or against the all-zero idle vector when nothing is scheduled.
  initial begin
    exp_t e;
    logic [17:0] want;
    wait (mon_en);
    forever begin
      @(negedge clock);
      for (int i = 0; i < NI; i++) begin
        want = 18'd0;
        if (exp_q[i].size() > 0 && exp_q[i][0].cyc == cyc) begin
          e = exp_q[i].pop_front();
          want = e.vec;
        end
        tests++;
        if (obs[i] !== want) begin
          fails++;
          $display("FAIL outputs dut%0d cyc %0d: got %b required %b", i, cyc, obs[i], want);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < NI; i++) free_at[i] = INF;
    drive(0, 6'd0, 2'd0, 1);
    mon_en = 1'b1;
    drive(0, 6'd0, 2'd0, 1);
    drive(0, 6'd0, 2'd0, 0);

    issue(6'b100011, 2'b00);                       // LW
    for (int j = 0; j < 3; j++) drive(1, 6'b101000, 2'b01, 0);  // ignored while busy
    issue(6'b101000, 2'b11);                       // SB
    issue(6'b101011, 2'b00);                       // SW
    issue(6'b101011, 2'b10);                       // SW misaligned
    issue(6'b001000, 2'b00);                       // ADDI
    drive(1, 6'b100001, 2'b01, 0);                 // held start while busy
    issue(6'b100001, 2'b00);                       // LH, reset in RD_WAIT
    drive(0, 6'd0, 2'd0, 0);
    drive(0, 6'd0, 2'd0, 1);
    drive(0, 6'd0, 2'd0, 0);
    issue(6'b100001, 2'b10);                       // LH
    issue(6'b100001, 2'b01);                       // LH misaligned
    issue(6'b101001, 2'b10);                       // SH
    issue(6'b101011, 2'b00);                       // SW then LB back-to-back
    issue(6'b100000, 2'b11);

    for (int n = 0; n < 600; n++) begin
      drive(($urandom % 3) == 0, pick_op($urandom_range(0, 9)),
            2'($urandom_range(0, 3)), ($urandom % 80) == 0);
    end

    begin
      int guard = 0;
      while (!(cyc >= free_at[0] && cyc >= free_at[1]) && guard < 100) begin
        drive(0, 6'd0, 2'd0, 0);
        guard++;
      end
    end
    drive(0, 6'd0, 2'd0, 0);
    drive(0, 6'd0, 2'd0, 0);
    @(negedge clock);
    #1;
    for (int i = 0; i < NI; i++) begin
      tests++;
      if (exp_q[i].size() != 0) begin
        fails++;
        $display("FAIL drain dut%0d: %0d expected cycles left, required 0", i, exp_q[i].size());
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_access_seq.md
Name: mem_access_seq

Overview:
- Load/store sequencer invoked by the main control FSM after it has placed the effective address (base + sign-extended imm) in ALUOut.
- Drives memory, MDR and register-file write controls for LW/LH/LB/SW/SH/SB.
- Handles the fixed memory read latency and the read-modify-write needed for SH/SB.
- Returns a one-cycle done pulse, or an exception pulse for misaligned or unsupported accesses.

Parameters:
- MEM_LAT, 2, memory read latency in cycles from address valid to data valid; legal range 1..7.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high; rising edge of clock
- start  in  1  request from control FSM; sampled only in IDLE
- op_code  in  6  instruction opcode, latched on accepted start
- addr_lsb  in  2  ALUOut[1:0], latched on accepted start
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse, access complete
- exc_align  out  1  one-cycle pulse, misaligned access; no memory or register write occurs
- exc_opcode  out  1  one-cycle pulse, start with non-load/store opcode
- i_or_d  out  2  memory address select; 01 = ALUOut, 00 = PC
- memory_write  out  1  memory write enable
- mdr_write  out  1  MDR load enable
- load_size  out  2  load extractor: 00 word, 01 half, 10 byte
- store_size  out  2  store merger: 00 word, 01 half, 10 byte
- reg_write  out  1  register file write enable
- mem_to_reg  out  3  write-back select; 001 = load extractor
- reg_dist_ctrl  out  2  destination select; 00 = rt

Behaviour:
- All outputs are registered. Reset value of every output is 0, and the FSM returns to IDLE.
- Reset mid-operation aborts immediately. memory_write and reg_write are 0 in the cycle after reset; no done is issued.
- States: IDLE, CHECK, RD_WAIT, RD_LATCH, WB, WR, DONE.
- IDLE:
  - start=1 latches op_code and addr_lsb, then goes to CHECK (cycle T+1).
  - start while busy is ignored.
- CHECK:
  - Opcode not in {LB 100000, LH 100001, LW 100011, SB 101000, SH 101001, SW 101011}: pulse exc_opcode, go to IDLE.
  - Misaligned access (LW/SW with addr_lsb != 00; LH/SH with addr_lsb[0]=1): pulse exc_align, go to IDLE. Byte accesses are never misaligned.
  - SW: go to WR.
  - Any load, SH or SB: go to RD_WAIT and load the 3-bit counter with MEM_LAT-1.
- RD_WAIT:
  - i_or_d=01, memory_write=0.
  - Decrement the counter; at 0 go to RD_LATCH. Stays exactly MEM_LAT cycles.
- RD_LATCH: i_or_d=01, mdr_write=1, for one cycle. Loads go to WB; SH/SB go to WR.
- WB:
  - reg_write=1, mem_to_reg=001, reg_dist_ctrl=00.
  - load_size = 00 (LW), 01 (LH), 10 (LB).
  - Go to DONE.
- WR:
  - i_or_d=01, memory_write=1 for exactly one cycle.
  - store_size = 00 (SW), 01 (SH), 10 (SB). The merger combines MDR with B using addr_lsb.
  - Go to DONE.
- DONE: done=1, all enables 0, go to IDLE. A new start is accepted in the cycle after DONE.
- Latency from start-accept cycle T:
  - SW: done at T+3.
  - Loads, SH, SB: done at T+MEM_LAT+4. With MEM_LAT=2, done is at T+6.
  - Exceptions: pulse at T+2.
- load_size and store_size hold their value from CHECK until IDLE, so the datapath sees stable sizes.
- Every output not explicitly set in a state is 0 in that state.
- done, exc_align and exc_opcode are mutually exclusive, and at most one pulse is issued per start.

Decomposition:
- Shared package holds:
  - opcode constants (LB/LH/LW/SB/SH/SW);
  - size encodings (SZ_WORD/SZ_HALF/SZ_BYTE);
  - i_or_d codes (IOD_PC, IOD_ALUOUT);
  - mem_to_reg code MTR_MEM;
  - state encoding.
- No sub-module. The latency counter is inline. The byte/half extractor and merger remain separate datapath blocks.

Test Plan:
- LW, addr_lsb=00, MEM_LAT=2, start at T -> RD_WAIT T+2..T+3, mdr_write at T+4, reg_write with mem_to_reg=001 and load_size=00 at T+5, done at T+6; memory_write never asserted.
- SB, addr_lsb=11 -> mdr_write at T+4, memory_write with store_size=10 at T+5 only, done at T+6, reg_write never asserted.
- SW, addr_lsb=00 -> memory_write at T+2, done at T+3. Repeat with addr_lsb=10 -> exc_align at T+2, no memory_write, no done.
- op_code=001000 (ADDI) with start -> exc_opcode at T+2, busy low from T+3; start held high during busy is ignored.
- LH started, reset asserted during RD_WAIT -> all outputs 0 the next cycle, no done/reg_write. A subsequent LH with MEM_LAT=5 gives done at T+9.
- Back-to-back: SW then LB issued in the cycle after done -> the second access is accepted, with correct sizes and no overlap of memory_write and mdr_write.
